// File: rtl/fulladder_seq_ctrl.sv
// Bit-serial sequencer for the registered, clock-gated fulladder datapath.
// Scan-mode entry and the SCAN state are built only when FA_CTRL_SCAN_EN is defined.
//
// state | meaning
// IDLE  | ready for a request (or scan entry)
// LOAD  | adder input regs capture bit i and carry
// EVAL  | adder output regs capture sum/carry
// CAPT  | clock gated off, store sum[i] and carry
// DONE  | result held until rsp_ready
// SCAN  | clock mux on scan clock, ungated

module fulladder_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             cg_en,
    input  logic             scan_req,
    output logic             Scan_en
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, EVAL, CAPT, DONE
`ifdef FA_CTRL_SCAN_EN
        , SCAN
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q, idx_n;
    logic             last_bit;
    logic             cg_en_d;

    assign idx_n    = idx_q + IW'(1);
    assign last_bit = (idx_q == IW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cg_en_d = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef FA_CTRL_SCAN_EN
                if (scan_req)
                    state_d = SCAN;
                else if (req_valid)
                    state_d = LOAD;
`else
                if (req_valid)
                    state_d = LOAD;
`endif
            end
            LOAD: state_d = EVAL;
            EVAL: state_d = CAPT;
            CAPT: state_d = last_bit ? DONE : LOAD;
            DONE: if (rsp_ready) state_d = IDLE;
`ifdef FA_CTRL_SCAN_EN
            SCAN: if (!scan_req) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        // cg_en is registered, so it is decoded from the state being entered
        if (state_d == LOAD || state_d == EVAL)
            cg_en_d = 1'b1;
`ifdef FA_CTRL_SCAN_EN
        if (state_d == SCAN)
            cg_en_d = 1'b1;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            fa_a    <= 1'b0;
            fa_b    <= 1'b0;
            fa_c    <= 1'b0;
            cg_en   <= 1'b0;
        end else begin
            state_q <= state_d;
            cg_en   <= cg_en_d;
            if (state_q == IDLE && state_d == LOAD) begin
                a_q     <= req_a;
                b_q     <= req_b;
                carry_q <= req_cin;
                idx_q   <= '0;
                fa_a    <= req_a[0];
                fa_b    <= req_b[0];
                fa_c    <= req_cin;
            end
            if (state_q == CAPT) begin
                sum_q[idx_q] <= fa_sum;
                carry_q      <= fa_carry;
                if (!last_bit) begin
                    idx_q <= idx_n;
                    fa_a  <= a_q[idx_n];
                    fa_b  <= b_q[idx_n];
                    fa_c  <= fa_carry;
                end
            end
        end
    end

`ifdef FA_CTRL_SCAN_EN
    always_ff @(posedge Clock) begin
        if (Reset)
            Scan_en <= 1'b0;
        else
            Scan_en <= (state_d == SCAN);
    end
`else
    logic unused_scan_req;
    assign unused_scan_req = scan_req;
    assign Scan_en         = 1'b0;
`endif

    assign req_ready = (state_q == IDLE) && !Reset;
    assign rsp_valid = (state_q == DONE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;

endmodule

// File: tb/tb_fulladder_seq_ctrl.sv
// Testbench for fulladder_seq_ctrl with a two-stage registered adder model.
// Scan scenarios are exercised when FA_CTRL_SCAN_EN is defined.

module tb_fulladder_seq_ctrl;

    localparam int W = 8;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_cin = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         fa_a, fa_b, fa_c;
    logic         fa_sum = 1'b0;
    logic         fa_carry = 1'b0;
    logic         cg_en;
    logic         scan_req = 1'b0;
    logic         Scan_en;

    int n_cmp = 0;
    int n_fail = 0;

    fulladder_seq_ctrl #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
        .fa_sum(fa_sum), .fa_carry(fa_carry),
        .cg_en(cg_en), .scan_req(scan_req), .Scan_en(Scan_en)
    );

    always #5 Clock = ~Clock;

    // Registered adder: input regs then output regs, both on the gated clock
    logic in_a = 1'b0, in_b = 1'b0, in_c = 1'b0;
    always @(posedge Clock) begin
        if (cg_en) begin
            in_a     <= fa_a;
            in_b     <= fa_b;
            in_c     <= fa_c;
            fa_sum   <= in_a ^ in_b ^ in_c;
            fa_carry <= (in_a & in_b) | (in_a & in_c) | (in_b & in_c);
        end
    end

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Presents a request and returns at the negedge of the first rsp_valid cycle
    task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             output logic rdy, output int lat, output int cgc);
        @(negedge Clock);
        rdy = req_ready;
        req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
        @(negedge Clock);
        req_valid = 1'b0;
        lat = 1;
        cgc = 0;
        while (!rsp_valid && lat < 200) begin
            if (cg_en) cgc++;
            @(negedge Clock);
            lat++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge Clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
        n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_during: got %b want 0", req_ready); end
        Reset = 1'b0;
        @(negedge Clock);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
        n_cmp++;
        if ({rsp_valid, rsp_sum, rsp_cout, fa_a, fa_b, fa_c, cg_en, Scan_en} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all 0", {rsp_valid, rsp_sum, rsp_cout, fa_a, fa_b, fa_c, cg_en, Scan_en});
        end
    endtask

    task automatic test_basic();
        logic rdy; int lat, cgc;
        start_req(8'h5A, 8'h33, 1'b0, rdy, lat, cgc);
        n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", rdy); end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: rsp_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_sum !== 8'h8D) begin n_fail++; $display("FAIL basic_sum: got %h want 8d", rsp_sum); end
        n_cmp++; if (rsp_cout !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b want 0", rsp_cout); end
        n_cmp++; if (lat != 3 * W + 1) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, 3 * W + 1); end
        n_cmp++; if (cgc != 2 * W) begin n_fail++; $display("FAIL basic_cg_budget: got %0d want %0d", cgc, 2 * W); end
        finish_rsp();
    endtask

    task automatic test_carry();
        logic rdy; int lat, cgc;
        start_req(8'hFF, 8'h01, 1'b0, rdy, lat, cgc);
        n_cmp++; if ({rsp_cout, rsp_sum} !== 9'h100) begin n_fail++; $display("FAIL carry_ripple: got %h want 100", {rsp_cout, rsp_sum}); end
        finish_rsp();
        start_req(8'h00, 8'h00, 1'b1, rdy, lat, cgc);
        n_cmp++; if ({rsp_cout, rsp_sum} !== 9'h001) begin n_fail++; $display("FAIL carry_cin_only: got %h want 001", {rsp_cout, rsp_sum}); end
        finish_rsp();
    endtask

    task automatic test_random();
        logic rdy; int lat, cgc;
        logic [W-1:0] a, b; logic cin; logic [W:0] e;
        for (int k = 0; k < 20; k++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
            e = ref_add(a, b, cin);
            start_req(a, b, cin, rdy, lat, cgc);
            n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want 1", k, rdy); end
            n_cmp++; if ({rsp_cout, rsp_sum} !== e) begin n_fail++; $display("FAIL rand_result[%0d]: %h+%h+%b got %h want %h", k, a, b, cin, {rsp_cout, rsp_sum}, e); end
            n_cmp++; if (lat != 3 * W + 1 || cgc != 2 * W) begin n_fail++; $display("FAIL rand_timing[%0d]: lat %0d cg %0d want %0d %0d", k, lat, cgc, 3 * W + 1, 2 * W); end
            repeat ($urandom_range(0, 2)) @(negedge Clock);
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        logic rdy; int lat, cgc;
        logic [W-1:0] a, b; logic cin; logic [W:0] e;
        int bad;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
        e = ref_add(a, b, cin);
        start_req(a, b, cin, rdy, lat, cgc);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_cout, rsp_sum} !== e || cg_en !== 1'b0) bad++;
            @(negedge Clock);
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: %0d bad cycles, last valid %b ready %b result %h want %h", bad, rsp_valid, req_ready, {rsp_cout, rsp_sum}, e); end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_11: got %b want 1", rsp_valid); end
        finish_rsp();
        n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_idle_gap: valid/ready got %b want 01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_reset_midop();
        logic rdy; int lat, cgc; int seen;
        @(negedge Clock);
        req_a = 8'hA7; req_b = 8'h5C; req_cin = 1'b1; req_valid = 1'b1;
        @(negedge Clock);
        req_valid = 1'b0;
        repeat (16) @(negedge Clock);
        n_cmp++; if (cg_en !== 1'b1) begin n_fail++; $display("FAIL midop_eval_cg: got %b want 1", cg_en); end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_sum, rsp_cout, fa_a, fa_b, fa_c, cg_en, Scan_en} !== '0) begin
            n_fail++;
            $display("FAIL midop_outputs: got %b want all 0", {rsp_valid, rsp_sum, rsp_cout, fa_a, fa_b, fa_c, cg_en, Scan_en});
        end
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (rsp_valid !== 1'b0 || cg_en !== 1'b0) seen++;
            @(negedge Clock);
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL midop_no_rsp: %0d active cycles want 0", seen); end
        start_req(8'h10, 8'h20, 1'b0, rdy, lat, cgc);
        n_cmp++; if ({rsp_valid, rsp_cout, rsp_sum} !== 10'h230) begin n_fail++; $display("FAIL midop_followup: got %h want 230", {rsp_valid, rsp_cout, rsp_sum}); end
        finish_rsp();
    endtask

`ifdef FA_CTRL_SCAN_EN
    task automatic test_scan_arbitration();
        logic [W-1:0] a, b; logic cin; logic [W:0] e; int cyc, bad;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
        e = ref_add(a, b, cin);
        @(negedge Clock);
        req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
        @(negedge Clock);
        req_valid = 1'b0;
        cyc = 1; bad = 0;
        while (!rsp_valid && cyc < 200) begin
            if (cyc == 10) scan_req = 1'b1;
            if (Scan_en !== 1'b0) bad++;
            @(negedge Clock);
            cyc++;
        end
        n_cmp++; if ({rsp_cout, rsp_sum} !== e) begin n_fail++; $display("FAIL scan_busy_result: got %h want %h", {rsp_cout, rsp_sum}, e); end
        n_cmp++; if (bad != 0 || Scan_en !== 1'b0) begin n_fail++; $display("FAIL scan_deferred: %0d early cycles, Scan_en %b want 0", bad, Scan_en); end
        finish_rsp();
        n_cmp++; if (Scan_en !== 1'b0) begin n_fail++; $display("FAIL scan_idle_gap: Scan_en got %b want 0", Scan_en); end
        @(negedge Clock);
        n_cmp++; if ({Scan_en, cg_en, req_ready} !== 3'b110) begin n_fail++; $display("FAIL scan_entry: en/cg/ready got %b want 110", {Scan_en, cg_en, req_ready}); end
        repeat (3) @(negedge Clock);
        scan_req = 1'b0;
        @(negedge Clock);
        n_cmp++; if ({Scan_en, cg_en, req_ready} !== 3'b001) begin n_fail++; $display("FAIL scan_exit: en/cg/ready got %b want 001", {Scan_en, cg_en, req_ready}); end
    endtask

    task automatic test_simultaneous();
        int seen;
        @(negedge Clock);
        req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1; scan_req = 1'b1;
        @(negedge Clock);
        req_valid = 1'b0;
        n_cmp++; if ({req_ready, Scan_en} !== 2'b01) begin n_fail++; $display("FAIL simul_scan_wins: ready/en got %b want 01", {req_ready, Scan_en}); end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        n_cmp++; if ({Scan_en, cg_en} !== 2'b00) begin n_fail++; $display("FAIL scan_reset: en/cg got %b want 00", {Scan_en, cg_en}); end
        scan_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (rsp_valid !== 1'b0) seen++;
            @(negedge Clock);
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL simul_not_accepted: %0d rsp cycles want 0", seen); end
    endtask
`else
    task automatic test_scan_ignored();
        logic rdy; int lat, cgc; logic [W:0] e;
        scan_req = 1'b1;
        e = ref_add(8'h3C, 8'h4B, 1'b1);
        start_req(8'h3C, 8'h4B, 1'b1, rdy, lat, cgc);
        n_cmp++; if ({rsp_cout, rsp_sum} !== e) begin n_fail++; $display("FAIL noscan_result: got %h want %h", {rsp_cout, rsp_sum}, e); end
        n_cmp++; if (Scan_en !== 1'b0 || lat != 3 * W + 1) begin n_fail++; $display("FAIL noscan_accept: Scan_en %b lat %0d want 0 %0d", Scan_en, lat, 3 * W + 1); end
        finish_rsp();
        scan_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_random();
        test_backpressure();
        test_reset_midop();
`ifdef FA_CTRL_SCAN_EN
        test_scan_arbitration();
        test_simultaneous();
`else
        test_scan_ignored();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fulladder_seq_ctrl.md
# fulladder_seq_ctrl

Bit-serial sequencer for the registered, clock-gated `fulladder` datapath. It accepts WIDTH-bit add requests over a valid/ready handshake and feeds operand bits to the adder LSB-first. It steps the adder's gated clock through `cg_en`, feeds the adder's Carry back as the next carry-in, and returns the assembled sum. It also owns scan-mode entry, and drives `Scan_en` only when the datapath is idle.

## Interface
- `WIDTH`, 8 — operand/sum width in bits; legal range 1–32.
- `Clock`  in  1  — single system clock. Also the functional clock into the adder's clock mux.
- `Reset`  in  1  — synchronous, active-high.
- `req_valid`  in  1  — add request valid.
- `req_ready`  out  1  — controller can accept a request.
- `req_a`, `req_b`  in  WIDTH  — operands.
- `req_cin`  in  1  — carry-in.
- `rsp_valid`  out  1  — result valid.
- `rsp_ready`  in  1  — consumer accepts result.
- `rsp_sum`  out  WIDTH  — sum.
- `rsp_cout`  out  1  — final carry-out.
- `fa_a`, `fa_b`, `fa_c`  out  1  — drive adder A, B, C.
- `fa_sum`, `fa_carry`  in  1  — from adder Sum, Carry.
- `cg_en`  out  1  — adder clock-gate enable. Registered.
- `scan_req`  in  1  — request scan mode.
- `Scan_en`  out  1  — adder clock-mux select. Registered.

## Operation
- **States:** IDLE, LOAD, EVAL, CAPT, DONE, SCAN.
- **Adder step:** a cycle with `cg_en`=1. Adder registers update at the `Clock` edge ending that cycle. Each bit takes two steps: the input regs capture, then the output regs capture.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`: latch operands, set `carry` to `req_cin`, set bit index i=0, go to LOAD.
  - If `scan_req`=1 at the same time, SCAN wins and the request is not accepted.
- **LOAD:**
  - `fa_a`=a[i], `fa_b`=b[i], `fa_c`=carry, `cg_en`=1.
  - Go to EVAL.
- **EVAL:**
  - Same `fa_*` values held, `cg_en`=1.
  - Go to CAPT.
- **CAPT:**
  - `cg_en`=0.
  - At the end of the cycle: sum[i] ← `fa_sum`, carry ← `fa_carry`.
  - If i=WIDTH-1, go to DONE; else i+1 and go to LOAD.
- **DONE:**
  - `rsp_valid`=1; `rsp_sum` and `rsp_cout` are stable.
  - On `rsp_ready`, go to IDLE.
  - `req_ready`=0 while DONE is held.
- **SCAN:**
  - Entered only from IDLE.
  - `Scan_en`=1 and `cg_en`=1 (scan clock passes ungated). `req_ready`=0.
  - Exit to IDLE when `scan_req`=0. `Scan_en` drops in the same registered update.
- `fa_*` outputs hold their last value outside LOAD/EVAL.
- Index counter width is clog2(WIDTH), minimum 1. No wrap: the counter stops at WIDTH-1.

## Timing
- **Reset values:**
  - `req_ready`=0 during `Reset`; 1 in the first cycle after `Reset` deasserts.
  - All other outputs 0: `rsp_valid`, `rsp_sum`, `rsp_cout`, `fa_a`, `fa_b`, `fa_c`, `cg_en`, `Scan_en`.
  - State returns to IDLE.
- **Reset mid-operation** (any state, including SCAN and DONE): the in-flight result is discarded with no response. `cg_en` and `Scan_en` are 0 in the cycle after the reset edge.
- **Latency:** a request accepted at edge E0 produces `rsp_valid` visible in cycle 3·WIDTH+1 after E0.
- **Throughput:** one add per 3·WIDTH+1 cycles minimum, with a 1-cycle IDLE gap between transactions.
- **`cg_en` budget:** exactly 2·WIDTH cycles high per transaction.
- `scan_req` raised while busy is deferred until after DONE completes.

## Configuration
- **`FA_CTRL_SCAN_EN` defined:** SCAN state and `scan_req` handling are present as specified.
- **Undefined:**
  - SCAN state removed, `scan_req` ignored, `Scan_en` tied 0.
  - IDLE accepts requests regardless of `scan_req`.

## Test plan
- **Basic add:** WIDTH=8, a=0x5A, b=0x33, cin=0 → sum=0x8D, cout=0. `rsp_valid` in cycle 25 after accept; `cg_en` high for exactly 16 cycles.
- **Carry ripple:** a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Second case a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- **Backpressure:** `rsp_ready`=0 for 10 cycles after `rsp_valid`. Result must stay stable, `req_ready`=0 throughout. Accept on the 11th cycle, then IDLE one cycle.
- **Scan arbitration:** `scan_req` raised during bit 3. `Scan_en` must stay 0 until after DONE handshake. Then `Scan_en`=1, `cg_en`=1, `req_ready`=0. Dropping `scan_req` returns `Scan_en`=0 next cycle.
- **Reset mid-op:** `Reset` in EVAL of bit 5 → next cycle all outputs 0, no `rsp_valid`. A following request 0x10+0x20 returns 0x30.
- **Simultaneous:** `req_valid` and `scan_req` both high in IDLE → SCAN entered, request not accepted (`req_ready` low next cycle).
